ahb_to_apb_bridge: RTL and testbench

AHB-Lite slave to APB4 master bridge. It is the initiator for APB peripherals such as apb-attached SRAM, UART and timers on the RISC-V core peripheral bus. It converts each AHB-Lite single transfer into one APB SETUP/ACCESS sequence. It inserts AHB wait states until the APB completer answers, and maps PSLVERR onto the two-cycle AHB ERROR response.

---
 rtl/ahb_to_apb_bridge.sv | 143 ++++++++++++++
 tb/tb_ahb_to_apb_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge.
// Each AHB-Lite single transfer becomes one APB SETUP/ACCESS sequence. The
// bridge holds HREADYOUT low until the APB completer answers. PSLVERR is
// returned as the two-cycle AHB ERROR response.
//
// Ports:
//   PCLK, PRESET         clock and synchronous active-high reset
//   HSEL..HREADY         AHB-Lite address/data phase inputs
//   HRDATA, HREADYOUT,   AHB-Lite response outputs (registered)
//   HRESP
//   PADDR..PPROT         APB4 requester outputs (registered)
//   PRDATA, PREADY,      APB4 completer response inputs
//   PSLVERR
module ahb_to_apb_bridge #(
   parameter int unsigned ADDRWIDTH = 16
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   input  logic                 HSEL,
   input  logic [31:0]          HADDR,
   input  logic [1:0]           HTRANS,
   input  logic [2:0]           HSIZE,
   input  logic [3:0]           HPROT,
   input  logic                 HWRITE,
   input  logic [31:0]          HWDATA,
   input  logic                 HREADY,
   output logic [31:0]          HRDATA,
   output logic                 HREADYOUT,
   output logic                 HRESP,
   output logic [ADDRWIDTH-1:0] PADDR,
   output logic                 PSEL,
   output logic                 PENABLE,
   output logic                 PWRITE,
   output logic [31:0]          PWDATA,
   output logic [3:0]           PSTRB,
   output logic [2:0]           PPROT,
   input  logic [31:0]          PRDATA,
   input  logic                 PREADY,
   input  logic                 PSLVERR
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR1   = 3'd5,
      ST_ERR2   = 3'd6
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       req;
   logic       unsupported;
   logic       accept;
   logic [3:0] strb_dec;

   // Address bits above the APB window, unused HPROT bits and HTRANS[0] carry no meaning here
   logic unused;
   assign unused = ^{HADDR[31:ADDRWIDTH], HPROT[3:2], HTRANS[0]};

   assign req = HSEL & HTRANS[1] & HREADY;

   // Sizes above a word, or misaligned halfword/word accesses
   assign unsupported = (HSIZE > 3'd2)
                      | ((HSIZE == 3'd1) & HADDR[0])
                      | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

   // Byte-lane strobes for writes; reads never assert strobes
   always_comb begin
      strb_dec = 4'b0000;
      if (HWRITE) begin
         case (HSIZE)
            3'd0:    strb_dec = 4'b0001 << HADDR[1:0];
            3'd1:    strb_dec = 4'b0011 << {HADDR[1], 1'b0};
            3'd2:    strb_dec = 4'b1111;
            default: strb_dec = 4'b0000;
         endcase
      end
   end

   // Next-state decode; a new request is only looked at when the bus is ready for one
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            if (req) begin
               accept = 1'b1;
               if (unsupported)  state_nxt = ST_ERR1;
               else if (HWRITE)  state_nxt = ST_WAIT;
               else              state_nxt = ST_SETUP;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT:   state_nxt = ST_SETUP;
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (PREADY) state_nxt = PSLVERR ? ST_ERR1 : ST_DONE;
         end
         ST_ERR1:   state_nxt = ST_ERR2;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State and registered outputs; handshake outputs are set for the state being entered
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state     <= ST_IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= 32'h0;
         PSTRB     <= 4'h0;
         PPROT     <= 3'h0;
         HRDATA    <= 32'h0;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
      end else begin
         state     <= state_nxt;
         PSEL      <= (state_nxt == ST_SETUP) | (state_nxt == ST_ACCESS);
         PENABLE   <= (state_nxt == ST_ACCESS);
         HREADYOUT <= (state_nxt == ST_IDLE) | (state_nxt == ST_DONE) | (state_nxt == ST_ERR2);
         HRESP     <= (state_nxt == ST_ERR1) | (state_nxt == ST_ERR2);

         if (accept) begin
            PADDR  <= HADDR[ADDRWIDTH-1:0];
            PWRITE <= HWRITE;
            PSTRB  <= strb_dec;
            PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
         end

         // Write data arrives in the AHB data phase, one cycle after the address
         if (state == ST_WAIT) PWDATA <= HWDATA;

         if ((state == ST_ACCESS) & PREADY & ~PSLVERR & ~PWRITE) HRDATA <= PRDATA;
      end
   end

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Directed self-checking bench for ahb_to_apb_bridge.
module tb_ahb_to_apb_bridge;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [3:0]  HPROT;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic [15:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [2:0]  PPROT;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int errors = 0;
   int checks = 0;

   ahb_to_apb_bridge #(.ADDRWIDTH(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
      .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 ns after it
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic addr_phase(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                             input logic [3:0] prot);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = addr;
      HWRITE = wr;
      HSIZE  = size;
      HPROT  = prot;
   endtask

   task automatic bus_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
   endtask

   // Handshake outputs in one word: {PSEL, PENABLE, HREADYOUT, HRESP}
   function automatic logic [31:0] hs();
      return 32'({PSEL, PENABLE, HREADYOUT, HRESP});
   endfunction

   // Single write with PREADY high; strobe checked while PSEL is up
   task automatic write_seq(input string tag, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data, input logic [3:0] exp_strb);
      addr_phase(addr, 1'b1, size, 4'b0011);
      tick();
      bus_idle();
      HWDATA = data;
      tick();
      check({tag, "_strb"}, 32'(PSTRB), 32'(exp_strb));
      check({tag, "_hs_setup"}, hs(), 32'b1000);
      tick();
      tick();
      check({tag, "_hs_done"}, hs(), 32'b0010);
   endtask

   initial begin
      PRESET = 1'b1;
      HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HSIZE = 3'd0; HPROT = 4'h0;
      HWRITE = 1'b0; HWDATA = 32'h0; HREADY = 1'b1;
      PRDATA = 32'h0; PREADY = 1'b1; PSLVERR = 1'b0;
      tick();
      tick();
      PRESET = 1'b0;

      // Reset state
      check("rst_hs", hs(), 32'b0010);
      check("rst_paddr", 32'(PADDR), 32'h0);
      check("rst_pstrb", 32'(PSTRB), 32'h0);
      check("rst_pwdata", PWDATA, 32'h0);
      check("rst_hrdata", HRDATA, 32'h0);
      check("rst_pprot", 32'(PPROT), 32'h0);

      // Word write, 3 wait states
      addr_phase(32'h0000_0104, 1'b1, 3'd2, 4'b0011);
      tick();
      bus_idle();
      HWDATA = 32'hDEAD_BEEF;
      check("ww_wait_hs", hs(), 32'b0000);
      tick();
      check("ww_setup_hs", hs(), 32'b1000);
      check("ww_paddr", 32'(PADDR), 32'h0104);
      check("ww_pstrb", 32'(PSTRB), 32'hF);
      check("ww_pwdata", PWDATA, 32'hDEAD_BEEF);
      check("ww_pwrite", 32'(PWRITE), 32'h1);
      check("ww_pprot", 32'(PPROT), 32'h1);
      tick();
      check("ww_access_hs", hs(), 32'b1100);
      tick();
      check("ww_done_hs", hs(), 32'b0010);
      check("ww_paddr_hold", 32'(PADDR), 32'h0104);

      // Read with two PREADY-low cycles
      addr_phase(32'h0000_0208, 1'b0, 3'd2, 4'b0010);
      PRDATA = 32'h1234_5678;
      PREADY = 1'b0;
      tick();
      bus_idle();
      check("rd_setup_hs", hs(), 32'b1000);
      check("rd_pstrb", 32'(PSTRB), 32'h0);
      check("rd_pprot", 32'(PPROT), 32'h5);
      tick();
      check("rd_acc1_hs", hs(), 32'b1100);
      tick();
      check("rd_acc2_hs", hs(), 32'b1100);
      check("rd_acc2_paddr", 32'(PADDR), 32'h0208);
      tick();
      check("rd_acc3_hs", hs(), 32'b1100);
      check("rd_acc3_hrdata", HRDATA, 32'h0);
      PREADY = 1'b1;
      tick();
      check("rd_done_hs", hs(), 32'b0010);
      check("rd_hrdata", HRDATA, 32'h1234_5678);

      // Byte and halfword strobes
      write_seq("wb3", 32'h0000_0013, 3'd0, 32'h7700_0000, 4'b1000);
      write_seq("wh2", 32'h0000_0022, 3'd1, 32'h5566_0000, 4'b1100);

      // Misaligned halfword: error without any APB access
      addr_phase(32'h0000_0001, 1'b1, 3'd1, 4'b0011);
      tick();
      bus_idle();
      check("mis_err1_hs", hs(), 32'b0001);
      tick();
      check("mis_err2_hs", hs(), 32'b0011);
      tick();
      check("mis_idle_hs", hs(), 32'b0010);

      // PSLVERR on a read: two-cycle ERROR, HRDATA untouched
      addr_phase(32'h0000_0300, 1'b0, 3'd2, 4'b0011);
      PRDATA  = 32'hCAFE_F00D;
      PSLVERR = 1'b1;
      tick();
      bus_idle();
      tick();
      check("se_access_hs", hs(), 32'b1100);
      tick();
      PSLVERR = 1'b0;
      check("se_err1_hs", hs(), 32'b0001);
      tick();
      check("se_err2_hs", hs(), 32'b0011);
      tick();
      check("se_idle_hs", hs(), 32'b0010);
      check("se_hrdata", HRDATA, 32'h1234_5678);

      // Back-to-back write then read, read issued in the write's DONE cycle
      addr_phase(32'h0000_0400, 1'b1, 3'd2, 4'b0011);
      tick();
      bus_idle();
      HWDATA = 32'hA5A5_0001;
      tick();
      tick();
      tick();
      check("b2b_done_hs", hs(), 32'b0010);
      check("b2b_wr_paddr", 32'(PADDR), 32'h0400);
      addr_phase(32'h0000_0408, 1'b0, 3'd2, 4'b0011);
      PRDATA = 32'h0BAD_C0DE;
      tick();
      bus_idle();
      check("b2b_setup_hs", hs(), 32'b1000);
      check("b2b_rd_paddr", 32'(PADDR), 32'h0408);
      check("b2b_rd_pwrite", 32'(PWRITE), 32'h0);
      tick();
      tick();
      check("b2b_rd_done_hs", hs(), 32'b0010);
      check("b2b_hrdata", HRDATA, 32'h0BAD_C0DE);
      check("b2b_pwdata_hold", PWDATA, 32'hA5A5_0001);

      // Reset while stalled in ACCESS, then a clean read
      addr_phase(32'h0000_0500, 1'b0, 3'd2, 4'b0011);
      PREADY = 1'b0;
      tick();
      bus_idle();
      tick();
      check("rst_mid_access_hs", hs(), 32'b1100);
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      PREADY = 1'b1;
      check("rst_mid_hs", hs(), 32'b0010);
      addr_phase(32'h0000_0504, 1'b0, 3'd2, 4'b0011);
      PRDATA = 32'h5A5A_5A5A;
      tick();
      bus_idle();
      check("post_rst_setup_hs", hs(), 32'b1000);
      check("post_rst_paddr", 32'(PADDR), 32'h0504);
      tick();
      tick();
      check("post_rst_done_hs", hs(), 32'b0010);
      check("post_rst_hrdata", HRDATA, 32'h5A5A_5A5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
